prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// prog_loader: receives a length/data/checksum byte frame from a host stream,
// writes the data bytes into a small program memory and releases the processor
// core reset only after the whole frame checked out. The core fetches from the
// same memory through a registered read port that works in every state.
module prog_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rstn_ext,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] prog_addr,
    output logic [7:0]        prog_data,
    output logic              rstn_inter,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   wr_cnt_dbg
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    // Length bytes are 8 bits wide, the stored length and counter are ADDR_W+1.
    localparam logic [8:0]      DEPTH_B = 9'(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
    logic [7:0]        acc_q, acc_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              rsti_q, rsti_d;
    logic [7:0]        prog_data_q, prog_data_d;

    // Program memory: never reset, so a partially loaded or aborted image
    // leaves whatever was already written in place.
    logic [7:0]        mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;

    logic              xfer;

    // in_ready is a registered state decode, forced low while reset is held.
    assign in_ready   = ready_q & rstn_ext;
    assign xfer       = in_valid & in_ready;

    assign prog_data  = prog_data_q;
    assign rstn_inter = rsti_q;
    assign load_done  = done_q;
    assign load_err   = err_q;
    assign wr_cnt_dbg = wr_cnt_q;

    // Frame parser: next state, counters, accumulator and memory write strobe.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        wr_cnt_d  = wr_cnt_q;
        acc_d     = acc_q;
        mem_we    = 1'b0;
        mem_waddr = wr_cnt_q[ADDR_W-1:0];
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    if (in_data != 8'd0 && {1'b0, in_data} <= DEPTH_B) begin
                        len_d    = (ADDR_W + 1)'(in_data);
                        wr_cnt_d = '0;
                        acc_d    = 8'd0;
                        state_d  = S_DATA;
                    end else begin
                        state_d  = S_ERR;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    mem_we   = 1'b1;
                    acc_d    = acc_q ^ in_data;
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    if (wr_cnt_d == len_q) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    state_d = (in_data == acc_q) ? S_DONE : S_ERR;
                end
            end
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase
    end

    // Registered outputs are decoded from the next state so they line up
    // with the first cycle spent in that state.
    always_comb begin
        ready_d = (state_d == S_IDLE) || (state_d == S_DATA) || (state_d == S_CSUM);
        done_d  = (state_d == S_DONE);
        err_d   = (state_d == S_ERR);
        rsti_d  = (state_d == S_DONE);
    end

    // Fetch path: out-of-range addresses (only possible when DEPTH < 2**ADDR_W) read 0.
    always_comb begin
        prog_data_d = 8'd0;
        if ({1'b0, prog_addr} < DEPTH_A) begin
            prog_data_d = mem[prog_addr];
        end
    end

    // Loader state and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn_ext) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            wr_cnt_q    <= '0;
            acc_q       <= 8'd0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rsti_q      <= 1'b0;
            prog_data_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wr_cnt_q    <= wr_cnt_d;
            acc_q       <= acc_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rsti_q      <= rsti_d;
            prog_data_q <= prog_data_d;
        end
    end

    // Memory write port; the fetch register samples the old word on the
    // same edge, giving read-before-write behaviour.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= in_data;
        end
    end

endmodule
